// File: rtl/mainmenu_controller.sv
// Main-menu sequencer: debounces five buttons, moves the selection on frame boundaries,
// launches the chosen mode via valid/ready. Optional build macro: MENU_AUTOREPEAT_EN.
module mainmenu_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int NUM_OPTIONS     = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic       frame_tick,
    input  logic       start_ready,
    input  logic       game_done,
    output logic [2:0] sel_index,
    output logic       start_valid,
    output logic [2:0] start_mode,
    output logic       menu_active
);
    // Handshake: a start request transfers on a cycle where start_valid && start_ready;
    // start_mode is held constant from start_valid rising until that transfer.
    localparam int CW = 20;
    localparam int B_UP = 0, B_DN = 1, B_LT = 2, B_RT = 3, B_SEL = 4;

    typedef enum logic [1:0] {MENU, LAUNCH, RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  raw, sync1_q, sync2_q, deb_q, deb_dly_q, rise, rep, pend_q, pend_d;
    logic [CW-1:0] cnt_q [5];
    logic [2:0]  sel_q, sel_d, mode_q, mode_d, idx;

    assign raw  = {btn_sel, btn_right, btn_left, btn_down, btn_up};
    assign rise = deb_q & ~deb_dly_q;

    // Counter runs only while the synchronized level disagrees with the debounced one.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef MENU_AUTOREPEAT_EN
    logic [5:0] rep_cnt_q, rep_cnt_d;
    logic       rep_fire;

    // Counts frames with up/down held; fires at 30, then every 8 frames after.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_fire  = 1'b0;
        if (state_q != MENU || !(deb_q[B_UP] || deb_q[B_DN])) begin
            rep_cnt_d = '0;
        end else if (frame_tick) begin
            rep_cnt_d = (rep_cnt_q == 6'd38) ? 6'd31 : rep_cnt_q + 6'd1;
            rep_fire  = (rep_cnt_d == 6'd30) || (rep_cnt_d == 6'd38);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) rep_cnt_q <= '0;
        else         rep_cnt_q <= rep_cnt_d;
    end

    assign rep = {3'b000, rep_fire & deb_q[B_DN], rep_fire & deb_q[B_UP]};
`else
    assign rep = '0;
`endif

    assign idx = (sel_q >= 3'(NUM_OPTIONS)) ? 3'd0 : sel_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        // A rise in the same cycle as frame_tick survives into the next frame.
        pend_d  = (frame_tick ? 5'b0 : pend_q) | rise | rep;
        case (state_q)
            MENU: begin
                if (frame_tick) begin
                    sel_d = idx;
                    if (pend_q[B_SEL]) begin
                        mode_d  = idx;
                        state_d = LAUNCH;
                    end else if (pend_q[B_UP]) begin
                        case (idx)
                            3'd0:    sel_d = 3'd2;
                            3'd1:    sel_d = 3'd0;
                            3'd2:    sel_d = 3'd1;
                            3'd3:    sel_d = 3'd4;
                            default: sel_d = 3'd3;
                        endcase
                    end else if (pend_q[B_DN]) begin
                        case (idx)
                            3'd0:    sel_d = 3'd1;
                            3'd1:    sel_d = 3'd2;
                            3'd2:    sel_d = 3'd0;
                            3'd3:    sel_d = 3'd4;
                            default: sel_d = 3'd3;
                        endcase
                    end else if (pend_q[B_LT]) begin
                        if (idx == 3'd3)      sel_d = 3'd0;
                        else if (idx == 3'd4) sel_d = 3'd1;
                    end else if (pend_q[B_RT]) begin
                        if (idx == 3'd0)      sel_d = 3'd3;
                        else if (idx <= 3'd2) sel_d = 3'd4;
                    end
                end
            end
            LAUNCH: begin
                if (start_ready) state_d = RUN;
            end
            RUN: begin
                pend_d = '0;
                if (game_done) state_d = MENU;
            end
            default: state_d = MENU;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= MENU;
            sel_q   <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
        end
    end

    assign sel_index   = sel_q;
    assign start_mode  = mode_q;
    assign start_valid = (state_q == LAUNCH);
    assign menu_active = (state_q == MENU);

endmodule

// File: tb/tb_mainmenu_controller.sv
// Self-checking bench for mainmenu_controller with a short debounce window.
module tb_mainmenu_controller;
    localparam int DB = 4;
    localparam int UP = 0, DN = 1, LT = 2, RT = 3, SL = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] btn = '0;
    logic       frame_tick = 1'b0, start_ready = 1'b0, game_done = 1'b0;
    logic [2:0] sel_index, start_mode;
    logic       start_valid, menu_active;

    logic [2:0] exp_q[$];
    logic [2:0] exp;
    int total = 0, bad = 0;

    mainmenu_controller #(.DEBOUNCE_CYCLES(DB), .NUM_OPTIONS(5)) dut (
        .clock(clock), .resetn(resetn),
        .btn_up(btn[UP]), .btn_down(btn[DN]), .btn_left(btn[LT]),
        .btn_right(btn[RT]), .btn_sel(btn[SL]),
        .frame_tick(frame_tick), .start_ready(start_ready), .game_done(game_done),
        .sel_index(sel_index), .start_valid(start_valid),
        .start_mode(start_mode), .menu_active(menu_active)
    );

    always #5 clock = ~clock;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic press(input logic [4:0] mask, input int hold);
        @(posedge clock); #1 btn = mask;
        repeat (hold) @(posedge clock);
        #1 btn = '0;
        repeat (2 + DB + 4) @(posedge clock);
        #1;
    endtask

    task automatic do_frame();
        @(posedge clock); #1 frame_tick = 1'b1;
        @(posedge clock); #1 frame_tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        #2;
        total++; if (sel_index !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel_index); end
        total++; if (start_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", start_valid); end
        total++; if (start_mode !== 3'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", start_mode); end
        total++; if (menu_active !== 1'b1) begin bad++; $display("FAIL reset_active got=%b exp=1", menu_active); end
        @(negedge clock); resetn = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    task automatic test_debounce();
        exp_q.push_back(3'd1);
        press(5'b1 << DN, 7);
        total++; if (sel_index !== 3'd0) begin bad++; $display("FAIL pre_frame_sel got=%0d exp=0", sel_index); end
        do_frame();
        exp = exp_q.pop_front();
        total++; if (sel_index !== exp) begin bad++; $display("FAIL debounce_down got=%0d exp=%0d", sel_index, exp); end
        exp_q.push_back(3'd1);
        press(5'b1 << DN, 3);
        do_frame();
        exp = exp_q.pop_front();
        total++; if (sel_index !== exp) begin bad++; $display("FAIL glitch got=%0d exp=%0d", sel_index, exp); end
    endtask

    task automatic test_wrap();
        logic [4:0] m [5] = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00010};
        logic [2:0] e [5] = '{3'd0, 3'd2, 3'd0, 3'd1, 3'd2};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(e[i]);
            press(m[i], 8);
            do_frame();
            exp = exp_q.pop_front();
            total++; if (sel_index !== exp) begin bad++; $display("FAIL wrap_%0d got=%0d exp=%0d", i, sel_index, exp); end
        end
    endtask

    task automatic test_column();
        // from 2: right, left, up, right, right, down, left
        logic [4:0] m [7] = '{5'b01000, 5'b00100, 5'b00001, 5'b01000, 5'b01000, 5'b00010, 5'b00100};
        logic [2:0] e [7] = '{3'd4, 3'd1, 3'd0, 3'd3, 3'd3, 3'd4, 3'd1};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(e[i]);
            press(m[i], 8);
            do_frame();
            exp = exp_q.pop_front();
            total++; if (sel_index !== exp) begin bad++; $display("FAIL column_%0d got=%0d exp=%0d", i, sel_index, exp); end
        end
    endtask

    task automatic test_priority_handshake();
        int unstable = 0;
        exp_q.push_back(3'd1);
        press((5'b1 << SL) | (5'b1 << UP), 8);
        do_frame();
        exp = exp_q.pop_front();
        total++; if (sel_index !== exp) begin bad++; $display("FAIL prio_sel got=%0d exp=%0d", sel_index, exp); end
        total++; if (start_valid !== 1'b1) begin bad++; $display("FAIL prio_valid got=%b exp=1", start_valid); end
        total++; if (start_mode !== 3'd1) begin bad++; $display("FAIL prio_mode got=%0d exp=1", start_mode); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (start_valid !== 1'b1 || start_mode !== 3'd1) unstable++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL hold_stable got=%0d exp=0 unstable cycles", unstable); end
        @(posedge clock); #1 start_ready = 1'b1;
        @(posedge clock); #1 start_ready = 1'b0;
        @(negedge clock);
        total++; if (menu_active !== 1'b0) begin bad++; $display("FAIL run_active got=%b exp=0", menu_active); end
        total++; if (start_valid !== 1'b0) begin bad++; $display("FAIL run_valid got=%b exp=0", start_valid); end
        press(5'b1 << DN, 8);
        do_frame();
        total++; if (sel_index !== 3'd1) begin bad++; $display("FAIL run_ignore got=%0d exp=1", sel_index); end
        @(posedge clock); #1 game_done = 1'b1;
        @(posedge clock); #1 game_done = 1'b0;
        @(negedge clock);
        total++; if (menu_active !== 1'b1) begin bad++; $display("FAIL back_menu got=%b exp=1", menu_active); end
        exp_q.push_back(3'd1);
        do_frame();
        exp = exp_q.pop_front();
        total++; if (sel_index !== exp) begin bad++; $display("FAIL preserved got=%0d exp=%0d", sel_index, exp); end
    endtask

    task automatic test_reset_launch();
        press(5'b1 << DN, 8);
        do_frame();
        total++; if (sel_index !== 3'd2) begin bad++; $display("FAIL pre_launch_sel got=%0d exp=2", sel_index); end
        press(5'b1 << SL, 8);
        do_frame();
        total++; if (start_valid !== 1'b1 || start_mode !== 3'd2) begin
            bad++; $display("FAIL launch got=%b/%0d exp=1/2", start_valid, start_mode); end
        #2 resetn = 1'b0;
        #1;
        total++; if (start_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", start_valid); end
        total++; if (sel_index !== 3'd0) begin bad++; $display("FAIL async_sel got=%0d exp=0", sel_index); end
        total++; if (menu_active !== 1'b1) begin bad++; $display("FAIL async_active got=%b exp=1", menu_active); end
        @(negedge clock); resetn = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    task automatic test_hold();
        @(posedge clock); #1 btn = 5'b1 << DN;
        repeat (2 + DB + 4) @(posedge clock);
        for (int f = 1; f <= 46; f++) begin
`ifdef MENU_AUTOREPEAT_EN
            exp_q.push_back((f >= 39) ? 3'd0 : (f >= 31) ? 3'd2 : 3'd1);
`else
            exp_q.push_back(3'd1);
`endif
            do_frame();
            exp = exp_q.pop_front();
            total++; if (sel_index !== exp) begin bad++; $display("FAIL hold_f%0d got=%0d exp=%0d", f, sel_index, exp); end
        end
        #1 btn = '0;
        repeat (2 + DB + 4) @(posedge clock);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_column();
        test_priority_handshake();
        test_reset_launch();
        test_hold();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL queue_left got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mainmenu_controller.md
# mainmenu_controller

Sequencing controller for the main-menu screen. It debounces the five menu buttons and owns the selected-option index that drives `metadata[28:26]` of the main-menu pixel processor. Index updates are applied only on frame boundaries, so the selection box never tears mid-frame. On confirm, it hands the chosen mode to the game core with a valid/ready handshake, then holds the menu idle until the game reports completion.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a button's debounced level changes (range 2..2^20-1).
- `NUM_OPTIONS`, default 5: fixed at 5; options 0-2 form the left column, 3-4 the right column.

Ports:
- `clock`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel`  in  1 each  raw, asynchronous, active-high buttons.
- `frame_tick`  in  1  one-cycle pulse at the start of vertical blanking.
- `start_ready`  in  1  game core accepts the start request.
- `game_done`  in  1  one-cycle pulse when the game returns to the menu.
- `sel_index`  out  3  selected option; feeds `metadata[28:26]`.
- `start_valid`  out  1  start request pending.
- `start_mode`  out  3  option being launched; stable while `start_valid` is high.
- `menu_active`  out  1  high while the menu is displayed and accepting input.

## Operation
- Input path, per button: 2-flop synchronizer, then debounce counter, then rising-edge detect on the debounced level.
  - The counter resets whenever the synchronized level differs from the debounced level.
  - When it reaches `DEBOUNCE_CYCLES-1`, the debounced level flips.
- Each rising edge sets a sticky pending flag for that button. Flags are cleared on the next `frame_tick`.
- FSM states: MENU, LAUNCH, RUN.
- MENU: on `frame_tick`, evaluate pending flags using priority sel > up > down > left > right. At most one action per frame; all other pending flags are discarded.
  - sel: `start_mode` <= `sel_index`, then go to LAUNCH.
  - up/down: move within the column and wrap.
    - Left column: up 0->2, 1->0, 2->1; down 0->1, 1->2, 2->0.
    - Right column: up/down toggles 3<->4.
  - right: 0->3, 1->4, 2->4; no effect in the right column.
  - left: 3->0, 4->1; no effect in the left column.
  - Indices 5-7 are never produced. If one is ever seen, it is treated as 0 on the next evaluation.
- LAUNCH: `start_valid`=1 and `start_mode` is held.
  - On `start_valid && start_ready`, go to RUN.
  - Button pending flags are ignored and cleared each `frame_tick`.
- RUN: `menu_active`=0 and buttons are ignored. `sel_index` keeps its last value.
  - `game_done` returns the FSM to MENU. Pending flags are cleared on entry, so presses made during the game have no effect.
- `menu_active` = (state == MENU).

## Timing
- Reset values: `sel_index`=0, `start_valid`=0, `start_mode`=0, `menu_active`=1, state=MENU. All debounced levels are 0 and all counters and flags are 0.
- Button-to-flag latency: 2 cycles (sync) + `DEBOUNCE_CYCLES` + 1 cycle (edge) after the raw level settles.
- `sel_index` changes in the cycle after `frame_tick` is sampled high, and never at any other time.
- `start_valid` rises in the cycle after the `frame_tick` that consumed sel. It falls in the cycle after the handshake.
- An edge arriving in the same cycle as `frame_tick` is kept pending for the following frame, not lost.
- `start_ready` that is high while `start_valid` is low has no effect.
- `game_done` outside RUN is ignored.
- Asserting `resetn` low in any state forces the reset values immediately; LAUNCH is abandoned with no handshake.

## Configuration
- `MENU_AUTOREPEAT_EN` defined: a held debounced up/down re-sets its pending flag on every 8th `frame_tick`, after an initial 30 `frame_tick`s held. The frame counter resets on release and in non-MENU states.
- `MENU_AUTOREPEAT_EN` undefined: one move per press only, and no frame counter logic is present.

## Test plan
- Reset, then press down with `DEBOUNCE_CYCLES`=4: a pulse held ≥7 cycles gives `sel_index` 0->1 on the next `frame_tick`. A 3-cycle glitch produces no change.
- Wrap: from 0, up gives 2. Three downs across three frames go 2->0->1->2.
- Column moves: from 2, right gives 4. Then left gives 1. Right at 3 followed by another right stays 3.
- Up and sel pending in the same frame: sel wins, `sel_index` is unchanged, `start_valid`=1 with `start_mode`=current index, and the up is discarded.
- Handshake: hold `start_ready`=0 for 10 cycles and `start_valid` and `start_mode` stay stable. Then `start_ready`=1 moves to RUN with `menu_active`=0. Then `game_done` returns to MENU with `sel_index` preserved.
- Pull `resetn` low during LAUNCH: `start_valid` goes to 0 and `sel_index` to 0 asynchronously. With `MENU_AUTOREPEAT_EN`, holding down for 46 frames gives 3 moves (frames 1, 31, 39).
